// File: rtl/l1_pkg.sv
// -----------------------------------------------------------------------------
// l1_pkg -- shared definitions for the L1 refill controller.
//
// Contents:
//   IDX_W / WAY_N   set-index width and way count, taken from the core-wide
//                   `CORE_IDX_WIDTH and `L1_WAY_NUM macros (defaults below
//                   apply when the core configuration does not provide them)
//   state_e         refill FSM state encoding
//   beat_width()    BEAT_W = log2(BEATS)
//   tag_width()     TAG_W  = 32 - IDX_W - BEAT_W - 2
//   line_addr()     {tag, idx, beat, 2'b00} byte-address builder
//
// Configuration macro: L1_EVICT_WB_EN (used by l1_refill_ctrl).
// -----------------------------------------------------------------------------
`ifndef CORE_IDX_WIDTH
`define CORE_IDX_WIDTH 6
`endif
`ifndef L1_WAY_NUM
`define L1_WAY_NUM 4
`endif

package l1_pkg;

    localparam int IDX_W = `CORE_IDX_WIDTH;
    localparam int WAY_N = `L1_WAY_NUM;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_RD   = 3'd1,
        WB_REQ  = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_e;

    function automatic int beat_width(input int beats);
        return $clog2(beats);
    endfunction

    function automatic int tag_width(input int beats);
        return 32 - IDX_W - $clog2(beats) - 2;
    endfunction

    // Arguments arrive zero-extended to 32 bits, so the fields cannot overlap.
    function automatic logic [31:0] line_addr(input logic [31:0] tag,
                                              input logic [31:0] idx,
                                              input logic [31:0] beat,
                                              input int          beat_w);
        return (tag << (IDX_W + beat_w + 2)) | (idx << (beat_w + 2)) | (beat << 2);
    endfunction

endpackage

// File: rtl/l1_refill_ctrl_if.sv
// -----------------------------------------------------------------------------
// l1_refill_ctrl_if -- memory request/response bus of the L1 refill controller.
//
// Signals:
//   mem_req_val / mem_req_ready   request handshake
//   mem_req_we                    1 = write beat, 0 = line read
//   mem_req_addr                  byte address
//   mem_req_wdata                 write beat data
//   mem_rsp_val / mem_rsp_data    read beat return (no back-pressure)
//
// Modports: master = cache controller side, slave = memory side.
// -----------------------------------------------------------------------------
interface l1_refill_ctrl_if #(
    parameter int DATA_W = 32
) ();

    logic              mem_req_val;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [31:0]       mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_rsp_val;
    logic [DATA_W-1:0] mem_rsp_data;

    modport master (
        output mem_req_val, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_rsp_val, mem_rsp_data
    );

    modport slave (
        input  mem_req_val, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_rsp_val, mem_rsp_data
    );

endinterface

// File: rtl/l1_beat_cnt.sv
// -----------------------------------------------------------------------------
// l1_beat_cnt -- beat counter for line transfers.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       clear counter to 0 (wins over inc_i)
//   inc_i        advance by one, wrapping to 0 after BEATS-1
//   cnt_o        current beat number
//   last_o       cnt_o == BEATS-1
// -----------------------------------------------------------------------------
module l1_beat_cnt
    import l1_pkg::*;
#(
    parameter  int BEATS  = 4,
    localparam int BEAT_W = beat_width(BEATS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              inc_i,
    output logic [BEAT_W-1:0] cnt_o,
    output logic              last_o
);

    logic [BEAT_W-1:0] cnt_q;
    logic [BEAT_W-1:0] cnt_d;

    assign last_o = (cnt_q == BEAT_W'(BEATS - 1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = last_o ? '0 : cnt_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/l1_refill_ctrl.sv
// -----------------------------------------------------------------------------
// l1_refill_ctrl -- L1 miss handling: optional dirty-victim writeback followed
// by a line read, beat-by-beat fill of the data RAM and a final tag update.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   acc_val, hit               access from the LRU stage and its hit result
//   evict_val, victim_dirty    miss with all ways valid / victim needs writeback
//   way_vect, idx, tag         allocate way (one-hot), set index, missing tag
//   victim_tag                 tag held in the victim way
//   stall, done                hold the core / one-cycle replay pulse
//   mem (master modport)       memory request/response bus
//   vic_re, vic_beat,
//   vic_rdata                  victim data-RAM read (1-cycle latency)
//   fill_we, fill_idx,
//   fill_way, fill_beat,
//   fill_data                  data-RAM fill write
//   tag_we, tag_wdata          tag/valid write for the filled way
//
// Configuration: define L1_EVICT_WB_EN to include the dirty-victim writeback
// path (WB_RD/WB_REQ). Without it every miss goes straight to RD_REQ and the
// victim read port and mem_req_we are tied to 0.
// -----------------------------------------------------------------------------
module l1_refill_ctrl
    import l1_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int BEATS  = 4,
    localparam int BEAT_W = beat_width(BEATS),
    localparam int TAG_W  = tag_width(BEATS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               acc_val,
    input  logic               hit,
    input  logic               evict_val,
    input  logic [WAY_N-1:0]   way_vect,
    input  logic [IDX_W-1:0]   idx,
    input  logic [TAG_W-1:0]   tag,
    input  logic [TAG_W-1:0]   victim_tag,
    input  logic               victim_dirty,
    output logic               stall,
    output logic               done,
    l1_refill_ctrl_if.master   mem,
    output logic               vic_re,
    output logic [BEAT_W-1:0]  vic_beat,
    input  logic [DATA_W-1:0]  vic_rdata,
    output logic               fill_we,
    output logic [IDX_W-1:0]   fill_idx,
    output logic [WAY_N-1:0]   fill_way,
    output logic [BEAT_W-1:0]  fill_beat,
    output logic [DATA_W-1:0]  fill_data,
    output logic               tag_we,
    output logic [TAG_W-1:0]   tag_wdata
);

    state_e            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WAY_N-1:0]  way_q;
    logic [TAG_W-1:0]  tag_q;

    logic [BEAT_W-1:0] cnt;
    logic              cnt_last;
    logic              cnt_load;
    logic              cnt_inc;
    logic              miss;
    logic              fill;

`ifdef L1_EVICT_WB_EN
    logic [TAG_W-1:0]  vtag_q;
    logic [DATA_W-1:0] wdata_q;
    // Set for the first WB_REQ cycle, while vic_rdata is being captured; the
    // request is only raised once the beat sits in wdata_q so it stays stable.
    logic              rd_pend_q;
`else
    logic              unused_wb;
    assign unused_wb = ^{evict_val, victim_dirty, victim_tag, vic_rdata};
`endif

    assign miss = acc_val & ~hit;
    // Responses are only meaningful while a line read is outstanding.
    assign fill = (state_q == RD_DATA) & mem.mem_rsp_val;

    always_comb begin
        cnt_load = ((state_q == IDLE) & miss) | ((state_q == RD_REQ) & mem.mem_req_ready);
        cnt_inc  = fill;
`ifdef L1_EVICT_WB_EN
        cnt_inc  = fill | ((state_q == WB_REQ) & ~rd_pend_q & mem.mem_req_ready);
`endif
    end

    l1_beat_cnt #(
        .BEATS (BEATS)
    ) u_beat_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (cnt_load),
        .inc_i  (cnt_inc),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            way_q     <= '0;
            tag_q     <= '0;
`ifdef L1_EVICT_WB_EN
            vtag_q    <= '0;
            wdata_q   <= '0;
            rd_pend_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        idx_q <= idx;
                        tag_q <= tag;
                        way_q <= way_vect;
`ifdef L1_EVICT_WB_EN
                        vtag_q  <= victim_tag;
                        state_q <= (evict_val & victim_dirty) ? WB_RD : RD_REQ;
`else
                        state_q <= RD_REQ;
`endif
                    end
                end
`ifdef L1_EVICT_WB_EN
                WB_RD: begin
                    rd_pend_q <= 1'b1;
                    state_q   <= WB_REQ;
                end
                WB_REQ: begin
                    if (rd_pend_q) begin
                        wdata_q   <= vic_rdata;
                        rd_pend_q <= 1'b0;
                    end else if (mem.mem_req_ready) begin
                        state_q <= cnt_last ? RD_REQ : WB_RD;
                    end
                end
`endif
                RD_REQ: begin
                    if (mem.mem_req_ready) begin
                        state_q <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (fill && cnt_last) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Gated with rst_n so the core sees no stall while reset is held.
    assign stall = rst_n & ((state_q != IDLE) | miss);
    assign done  = (state_q == DONE);

`ifdef L1_EVICT_WB_EN
    assign mem.mem_req_val   = (state_q == RD_REQ) | ((state_q == WB_REQ) & ~rd_pend_q);
    assign mem.mem_req_we    = (state_q == WB_REQ);
    assign mem.mem_req_wdata = wdata_q;
    assign vic_re            = (state_q == WB_RD);
    assign vic_beat          = vic_re ? cnt : '0;
`else
    assign mem.mem_req_val   = (state_q == RD_REQ);
    assign mem.mem_req_we    = 1'b0;
    assign mem.mem_req_wdata = '0;
    assign vic_re            = 1'b0;
    assign vic_beat          = '0;
`endif

    always_comb begin
        mem.mem_req_addr = '0;
        if (state_q == RD_REQ) begin
            mem.mem_req_addr = line_addr(32'(tag_q), 32'(idx_q), 32'd0, BEAT_W);
        end
`ifdef L1_EVICT_WB_EN
        else if (state_q == WB_REQ) begin
            mem.mem_req_addr = line_addr(32'(vtag_q), 32'(idx_q), 32'(cnt), BEAT_W);
        end
`endif
    end

    assign fill_we   = fill;
    assign fill_idx  = idx_q;
    assign fill_way  = way_q;
    assign fill_beat = fill ? cnt : '0;
    assign fill_data = fill ? mem.mem_rsp_data : '0;
    assign tag_we    = fill & cnt_last;
    assign tag_wdata = tag_we ? tag_q : '0;

endmodule

// File: tb/tb_l1_refill_ctrl.sv
module tb_l1_refill_ctrl;

    localparam int IDX_W  = `CORE_IDX_WIDTH;
    localparam int WAY_N  = `L1_WAY_NUM;
    localparam int BEATS  = 4;
    localparam int BEAT_W = 2;
    localparam int TAG_W  = 32 - IDX_W - BEAT_W - 2;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [WAY_N-1:0]  way;
        logic [BEAT_W-1:0] beat;
        logic [31:0]       data;
        logic              tagwe;
        logic [TAG_W-1:0]  tag;
    } fill_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              acc_val, hit, evict_val, victim_dirty;
    logic [WAY_N-1:0]  way_vect;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag, victim_tag;
    logic              stall, done;
    logic              vic_re;
    logic [BEAT_W-1:0] vic_beat;
    logic [31:0]       vic_rdata;
    logic              fill_we, tag_we;
    logic [IDX_W-1:0]  fill_idx;
    logic [WAY_N-1:0]  fill_way;
    logic [BEAT_W-1:0] fill_beat;
    logic [31:0]       fill_data;
    logic [TAG_W-1:0]  tag_wdata;

    l1_refill_ctrl_if #(.DATA_W(32)) mem_if ();

    l1_refill_ctrl #(.DATA_W(32), .BEATS(BEATS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .acc_val      (acc_val),
        .hit          (hit),
        .evict_val    (evict_val),
        .way_vect     (way_vect),
        .idx          (idx),
        .tag          (tag),
        .victim_tag   (victim_tag),
        .victim_dirty (victim_dirty),
        .stall        (stall),
        .done         (done),
        .mem          (mem_if),
        .vic_re       (vic_re),
        .vic_beat     (vic_beat),
        .vic_rdata    (vic_rdata),
        .fill_we      (fill_we),
        .fill_idx     (fill_idx),
        .fill_way     (fill_way),
        .fill_beat    (fill_beat),
        .fill_data    (fill_data),
        .tag_we       (tag_we),
        .tag_wdata    (tag_wdata)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    done_cnt = 0;
    req_t  exp_req[$];
    fill_t exp_fill[$];
    req_t  mon_r;
    fill_t mon_f;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] rsp_word(input logic [TAG_W-1:0] t, input int b);
        return {t[15:0], 16'hA500} ^ 32'(b);
    endfunction

    function automatic logic [31:0] vic_word(input int b);
        return 32'hC0DE_0000 | 32'(b);
    endfunction

    // Victim data RAM: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        vic_rdata <= vic_re ? vic_word(int'(vic_beat)) : 32'hDEAD_BEEF;
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_if.mem_req_val && mem_if.mem_req_ready) begin
            if (exp_req.size() == 0) begin
                check("req_unexpected", {mem_if.mem_req_we, mem_if.mem_req_addr}, 0);
            end else begin
                mon_r = exp_req.pop_front();
                check("req_we", mem_if.mem_req_we, mon_r.we);
                check("req_addr", mem_if.mem_req_addr, mon_r.addr);
                if (mon_r.we) check("req_wdata", mem_if.mem_req_wdata, mon_r.wdata);
            end
        end
        if (fill_we) begin
            if (exp_fill.size() == 0) begin
                check("fill_unexpected", fill_we, 0);
            end else begin
                mon_f = exp_fill.pop_front();
                check("fill_idx", fill_idx, mon_f.idx);
                check("fill_way", fill_way, mon_f.way);
                check("fill_beat", fill_beat, mon_f.beat);
                check("fill_data", fill_data, mon_f.data);
                check("tag_we", tag_we, mon_f.tagwe);
                if (mon_f.tagwe) check("tag_wdata", tag_wdata, mon_f.tag);
            end
        end else if (tag_we) begin
            check("tag_we_alone", tag_we, 0);
        end
`ifndef L1_EVICT_WB_EN
        if (vic_re || mem_if.mem_req_we) check("wb_path_tied", {vic_re, mem_if.mem_req_we}, 0);
`endif
        if (done) done_cnt++;
    end

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {stall, done, mem_if.mem_req_val, mem_if.mem_req_we,
                               fill_we, tag_we, vic_re}, 0);
        check({name, "_addr"}, mem_if.mem_req_addr, 0);
        check({name, "_fill"}, {fill_idx, fill_way, fill_beat, tag_wdata}, 0);
        check({name, "_data"}, fill_data, 0);
    endtask

    task automatic run_hit();
        @(posedge clk); #1;
        acc_val = 1'b1; hit = 1'b1; evict_val = 1'b1; victim_dirty = 1'b1;
        idx = 6'(7); tag = TAG_W'(22'h3F0); way_vect = 4'b0010;
        repeat (3) begin
            @(negedge clk);
            check("hit_stall", stall, 0);
            check("hit_noreq", mem_if.mem_req_val, 0);
        end
        @(posedge clk); #1;
        acc_val = 1'b0; hit = 1'b0; evict_val = 1'b0; victim_dirty = 1'b0;
        @(negedge clk);
        check("hit_idle", {stall, mem_if.mem_req_val}, 0);
    endtask

    // One miss transaction. rdy_dly: cycles of request back-pressure on the
    // first request. rst_at >= 0: assert reset once that many fill beats have
    // been handed over.
    task automatic run_miss(input logic [IDX_W-1:0] i, input logic [TAG_W-1:0] t,
                            input logic [WAY_N-1:0] w, input logic ev, input logic dt,
                            input logic [TAG_W-1:0] vt, input int rdy_dly, input int rst_at);
        int  sent;
        bit  rd_acc, wb, fin, was_rst;
        int  d0;
        wb = 1'b0;
`ifdef L1_EVICT_WB_EN
        wb = ev & dt;
`endif
        if (wb) begin
            for (int b = 0; b < BEATS; b++) begin
                logic [BEAT_W-1:0] bb;
                bb = BEAT_W'(b);
                exp_req.push_back('{we: 1'b1, addr: {vt, i, bb, 2'b00}, wdata: vic_word(b)});
            end
        end
        exp_req.push_back('{we: 1'b0, addr: {t, i, 4'b0000}, wdata: 32'h0});
        for (int b = 0; b < BEATS; b++) begin
            exp_fill.push_back('{idx: i, way: w, beat: BEAT_W'(b), data: rsp_word(t, b),
                                 tagwe: (b == BEATS - 1), tag: t});
        end

        @(posedge clk); #1;
        acc_val = 1'b1; hit = 1'b0; evict_val = ev; victim_dirty = dt;
        idx = i; tag = t; way_vect = w; victim_tag = vt;
        @(negedge clk);
        check("miss_stall", stall, 1);
        @(posedge clk); #1;
        // Scramble the inputs: the DUT must work from its captured copies.
        acc_val = 1'b0; evict_val = 1'b0; victim_dirty = 1'b0;
        idx = '1; tag = '1; way_vect = '1; victim_tag = '1;

        d0 = done_cnt; sent = 0; rd_acc = 1'b0; fin = 1'b0; was_rst = 1'b0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            acc_val = (cyc == 1);  // must be ignored while busy
            mem_if.mem_req_ready = (cyc >= rdy_dly);
            mem_if.mem_rsp_val   = rd_acc && (sent < BEATS) && (sent != 2 || cyc % 2 == 0);
            mem_if.mem_rsp_data  = mem_if.mem_rsp_val ? rsp_word(t, sent) : 32'h5555_5555;
            @(negedge clk);
            if (cyc == 0 && !wb) check("rdreq_next", mem_if.mem_req_val, 1);
            if (cyc < rdy_dly && !wb) begin
                check("bp_val", mem_if.mem_req_val, 1);
                check("bp_addr", mem_if.mem_req_addr, {t, i, 4'b0000});
                check("bp_stall", stall, 1);
            end
            if (mem_if.mem_rsp_val && rd_acc) sent++;
            if (mem_if.mem_req_val && mem_if.mem_req_ready && !mem_if.mem_req_we) rd_acc = 1'b1;
            if (done) fin = 1'b1;
            @(posedge clk); #1;
            if (rst_at >= 0 && sent == rst_at && !fin) begin
                rst_n = 1'b0;
                mem_if.mem_rsp_val = 1'b1;
                #1;
                check_all_zero("rst_mid");
                exp_fill.delete();
                @(negedge clk);
                check_all_zero("rst_hold");
                @(posedge clk); #1;
                rst_n = 1'b1;
                acc_val = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stray_rsp_fill", fill_we, 0);
                    check("stray_rsp_stall", stall, 0);
                    @(posedge clk); #1;
                end
                was_rst = 1'b1;
                fin = 1'b1;
            end
        end
        acc_val = 1'b0;
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_val   = 1'b0;
        if (!fin) check("done_timeout", 0, 1);
        if (!was_rst) begin
            @(negedge clk);
            check("done_once", done, 0);
            check("stall_after_done", stall, 0);
            check("done_count", done_cnt - d0, 1);
        end
        check("req_left", exp_req.size(), 0);
        check("fill_left", exp_fill.size(), 0);
        exp_req.delete();
        exp_fill.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        acc_val = 1'b1; hit = 1'b0; evict_val = 1'b0; victim_dirty = 1'b0;
        way_vect = '0; idx = '0; tag = '0; victim_tag = '0;
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_val   = 1'b0;
        mem_if.mem_rsp_data  = '0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        acc_val = 1'b0;
        rst_n   = 1'b1;

        run_hit();
        // Clean miss.
        run_miss(6'(5), TAG_W'(22'h1234), 4'b0001, 1'b0, 1'b0, TAG_W'(0), 0, -1);
        // Request back-pressure for 5 cycles.
        run_miss(6'(9), TAG_W'(22'h02AB), 4'b0100, 1'b0, 1'b0, TAG_W'(0), 5, -1);
        // Dirty victim: writeback when enabled, straight read otherwise.
        run_miss(6'(3), TAG_W'(22'h0077), 4'b1000, 1'b1, 1'b1, TAG_W'(22'h00AB), 0, -1);
        // Eviction of a clean victim never writes back.
        run_miss(6'(12), TAG_W'(22'h3ABCD), 4'b0010, 1'b1, 1'b0, TAG_W'(22'h0055), 0, -1);
        // Reset in the middle of the fill, after beat 1.
        run_miss(6'(5), TAG_W'(22'h1234), 4'b0001, 1'b0, 1'b0, TAG_W'(0), 0, 2);
        // Recovery after reset.
        run_miss(6'(63), TAG_W'(22'h2FFFF), 4'b0100, 1'b0, 1'b0, TAG_W'(0), 2, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
